// File: rtl/fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch and next-PC stage of the KGP miniRISC core. Holds the
// program counter, fetches one instruction at a time over a req/ack handshake,
// presents the latched word to decode, and commits the next PC on exec_done
// using the decoder's CondJump/UncondJump/AddrSel controls, the branch operand
// register and an internal carry flag.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   Defined   : a fetch watchdog moves the FSM to HALT after TIMEOUT FETCH
//               cycles without ack and raises the sticky o_fetch_err.
//   Undefined : FETCH waits indefinitely, HALT is unreachable, o_fetch_err=0.
//
// Parameters
//   RESET_PC : PC loaded on reset.
//   TIMEOUT  : fetch watchdog limit in cycles (FETCH_TIMEOUT_EN only).
//
// Ports
//   clk            : clock, rising edge.
//   rst_n          : asynchronous active-low reset.
//   o_imem_req     : fetch request, high for the whole FETCH state.
//   o_imem_addr    : fetch address (equals o_pc).
//   i_imem_ack     : memory returns i_imem_rdata this cycle.
//   i_imem_rdata   : instruction word, valid with i_imem_ack.
//   o_instr        : latched instruction.
//   o_instr_valid  : o_instr valid for decode/execute (EXEC state).
//   o_pc           : current PC.
//   o_link_pc      : o_pc + 4, the bl writeback value.
//   i_exec_done    : current instruction finished; commit next PC.
//   i_cond_jump    : condition select (CondJump).
//   i_uncond_jump  : unconditional branch (UncondJump).
//   i_addr_sel     : target select (AddrSel).
//   i_rs_val       : branch operand register value.
//   i_carry_we     : update carry flag.
//   i_carry_in     : new carry value from the ALU.
//   o_fetch_err    : sticky fetch watchdog error.
// ----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_link_pc,
    input  logic        i_exec_done,
    input  logic [2:0]  i_cond_jump,
    input  logic        i_uncond_jump,
    input  logic [1:0]  i_addr_sel,
    input  logic [31:0] i_rs_val,
    input  logic        i_carry_we,
    input  logic        i_carry_in,
    output logic        o_fetch_err
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2,
        StHalt  = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_carry;

    logic        w_ld_instr;
    logic        w_ld_pc;

    // ------------------------------------------------------------------
    // Next-PC datapath
    // ------------------------------------------------------------------
    logic [31:0] w_pc_plus4;
    logic [31:0] w_off16;
    logic [31:0] w_off26;
    logic [31:0] w_target;
    logic        w_taken;
    logic [31:0] w_pc_next;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Word offsets: sign-extend, then scale by 4.
    assign w_off16 = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_off26 = {{4{r_instr[25]}}, r_instr[25:0], 2'b00};

    always_comb begin
        w_target = w_pc_plus4;
        case (i_addr_sel)
            2'b00:   w_target = w_pc_plus4 + w_off26;
            2'b01:   w_target = {i_rs_val[31:2], 2'b00};
            2'b10:   w_target = w_pc_plus4 + w_off16;
            default: w_target = w_pc_plus4;
        endcase
    end

    // Carry condition uses the registered flag, so a carry update on the
    // same edge as exec_done is not visible to that branch.
    always_comb begin
        w_taken = 1'b0;
        if (i_uncond_jump) begin
            w_taken = 1'b1;
        end else begin
            case (i_cond_jump)
                3'b001:  w_taken = i_rs_val[31];
                3'b010:  w_taken = (i_rs_val == 32'd0);
                3'b011:  w_taken = (i_rs_val != 32'd0);
                3'b100:  w_taken = r_carry;
                3'b101:  w_taken = ~r_carry;
                default: w_taken = 1'b0;
            endcase
        end
    end

    assign w_pc_next = w_taken ? w_target : w_pc_plus4;

`ifdef FETCH_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Fetch watchdog
    // ------------------------------------------------------------------
    // Counter holds the number of ack-less FETCH cycles already elapsed, so
    // it never needs to represent TIMEOUT itself.
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_next;
    logic            r_err;
    logic            w_err_set;
`endif

    // ------------------------------------------------------------------
    // FSM next-state and load strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_ld_instr   = 1'b0;
        w_ld_pc      = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        w_cnt_next   = r_cnt;
        w_err_set    = 1'b0;
`endif
        case (r_state)
            StIdle: begin
                w_state_next = StFetch;
`ifdef FETCH_TIMEOUT_EN
                w_cnt_next   = '0;
`endif
            end
            StFetch: begin
                if (i_imem_ack) begin
                    // An ack on the final watchdog cycle still wins.
                    w_state_next = StExec;
                    w_ld_instr   = 1'b1;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (r_cnt == CntLast) begin
                    w_state_next = StHalt;
                    w_err_set    = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
`endif
            end
            StExec: begin
                if (i_exec_done) begin
                    w_state_next = StFetch;
                    w_ld_pc      = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    w_cnt_next   = '0;
`endif
                end
            end
            StHalt: begin
                // Left only by reset.
                w_state_next = StHalt;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_ld_pc) begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= 32'd0;
        end else if (w_ld_instr) begin
            r_instr <= i_imem_rdata;
        end
    end

    // Carry tracks the ALU independently of the fetch state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (i_carry_we) begin
            r_carry <= i_carry_in;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign o_fetch_err = r_err;
`else
    // Watchdog limit has no effect without the watchdog.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);

    assign o_fetch_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_imem_req    = (r_state == StFetch);
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = (r_state == StExec);
    assign o_pc          = r_pc;
    assign o_link_pc     = w_pc_plus4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Directed bench for fetch_pc_unit with a scoreboard. The driver pushes the
// expected fetch address whenever it commits an instruction (exec_done) and
// the expected decode view (instr, pc, link_pc) whenever it acks a fetch; a
// separate monitor pops and compares when the DUT raises imem_req or
// instr_valid. Next-PC values are hand-computed per vector.
// ----------------------------------------------------------------------------
module tb_fetch_pc_unit;

    localparam logic [31:0] RstPc = 32'h0000_0100;
    localparam int unsigned Tmo   = 16;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] link_pc;
    logic        exec_done;
    logic [2:0]  cond_jump;
    logic        uncond_jump;
    logic [1:0]  addr_sel;
    logic [31:0] rs_val;
    logic        carry_we;
    logic        carry_in;
    logic        fetch_err;

    fetch_pc_unit #(
        .RESET_PC (RstPc),
        .TIMEOUT  (Tmo)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ack    (imem_ack),
        .i_imem_rdata  (imem_rdata),
        .o_instr       (instr),
        .o_instr_valid (instr_valid),
        .o_pc          (pc),
        .o_link_pc     (link_pc),
        .i_exec_done   (exec_done),
        .i_cond_jump   (cond_jump),
        .i_uncond_jump (uncond_jump),
        .i_addr_sel    (addr_sel),
        .i_rs_val      (rs_val),
        .i_carry_we    (carry_we),
        .i_carry_in    (carry_in),
        .o_fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] link;
    } exec_t;

    logic [31:0] fetch_q[$];
    exec_t       exec_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] mpc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin : monitor
        logic        prev_req;
        logic        prev_valid;
        logic [31:0] cur_addr;
        exec_t       cur_ex;
        prev_req   = 1'b0;
        prev_valid = 1'b0;
        cur_addr   = '0;
        cur_ex     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req   = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (imem_req && !prev_req) begin
                    check("fetch_expected", 32'(fetch_q.size() != 0), 32'd1);
                    if (fetch_q.size() != 0) begin
                        cur_addr = fetch_q.pop_front();
                        check("fetch_addr", imem_addr, cur_addr);
                    end
                end else if (imem_req) begin
                    check("fetch_addr_stable", imem_addr, cur_addr);
                end
                if (instr_valid && !prev_valid) begin
                    check("exec_expected", 32'(exec_q.size() != 0), 32'd1);
                    if (exec_q.size() != 0) begin
                        cur_ex = exec_q.pop_front();
                        check("exec_instr", instr, cur_ex.instr);
                        check("exec_pc", pc, cur_ex.pc);
                        check("exec_link_pc", link_pc, cur_ex.link);
                    end
                end else if (instr_valid) begin
                    check("exec_instr_stable", instr, cur_ex.instr);
                end
                prev_req   = imem_req;
                prev_valid = instr_valid;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers (called at posedge + #1)
    // ------------------------------------------------------------------
    task automatic wait_req();
        int t;
        t = 0;
        while (!imem_req && t < 64) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("req_wait", 32'(imem_req), 32'd1);
    endtask

    task automatic idle_ctl();
        exec_done   = 1'b0;
        cond_jump   = 3'b000;
        uncond_jump = 1'b0;
        addr_sel    = 2'b11;
        rs_val      = 32'd0;
        carry_we    = 1'b0;
        carry_in    = 1'b0;
    endtask

    // One instruction: wait for fetch, ack after ack_dly cycles, hold EXEC
    // for ex_dly cycles, then commit with the given branch controls.
    task automatic run_vec(input logic [31:0] rdata, input int ack_dly, input int ex_dly,
                           input logic [2:0] cj, input logic uj, input logic [1:0] sel,
                           input logic [31:0] rs, input logic cwe, input logic cin,
                           input logic [31:0] exp_next);
        exec_t e;
        wait_req();
        // exec_done outside EXEC must be ignored.
        for (int k = 0; k < ack_dly; k++) begin
            exec_done = 1'b1;
            @(posedge clk);
            #1;
        end
        exec_done = 1'b0;
        e.instr = rdata;
        e.pc    = mpc;
        e.link  = mpc + 32'd4;
        exec_q.push_back(e);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        @(posedge clk);
        #1;
        // ack outside FETCH must be ignored.
        for (int k = 0; k < ex_dly; k++) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
        end
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0BAD_0BAD;
        cond_jump   = cj;
        uncond_jump = uj;
        addr_sel    = sel;
        rs_val      = rs;
        carry_we    = cwe;
        carry_in    = cin;
        fetch_q.push_back(exp_next);
        exec_done   = 1'b1;
        @(posedge clk);
        #1;
        idle_ctl();
        mpc = exp_next;
    endtask

    task automatic reset_release();
        fetch_q.push_back(RstPc);
        mpc = RstPc;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("req_low_at_release", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        check("req_one_cycle_after_release", 32'(imem_req), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        idle_ctl();
        mpc = RstPc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc", pc, RstPc);
        check("rst_imem_addr", imem_addr, RstPc);
        check("rst_link_pc", link_pc, RstPc + 32'd4);
        check("rst_instr", instr, 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);

        reset_release();

        //       rdata          ack ex  cj      uj    sel    rs            we    cin   next
        run_vec(32'h2000_0004, 0, 0, 3'b000, 1'b0, 2'b11, 32'h0,        1'b0, 1'b0, 32'h0000_0104);
        run_vec(32'h1111_0000, 2, 1, 3'b000, 1'b0, 2'b00, 32'h0,        1'b0, 1'b0, 32'h0000_0108);
        run_vec(32'h0800_003D, 0, 0, 3'b000, 1'b1, 2'b00, 32'h0,        1'b0, 1'b0, 32'h0000_0200);
        // bz taken / not taken
        run_vec(32'h1234_FFFE, 0, 0, 3'b010, 1'b0, 2'b10, 32'h0,        1'b0, 1'b0, 32'h0000_01FC);
        run_vec(32'h1234_FFFE, 1, 0, 3'b010, 1'b0, 2'b10, 32'h5,        1'b0, 1'b0, 32'h0000_0200);
        run_vec(32'h1234_FFFE, 0, 2, 3'b010, 1'b0, 2'b10, 32'h5,        1'b0, 1'b0, 32'h0000_0204);
        // br to register
        run_vec(32'h5555_0000, 0, 0, 3'b000, 1'b1, 2'b01, 32'h0000_0403, 1'b0, 1'b0, 32'h0000_0400);
        // bcy with carry set on the same edge sees old carry (0)
        run_vec(32'h4400_0010, 0, 0, 3'b100, 1'b0, 2'b10, 32'h0,        1'b1, 1'b1, 32'h0000_0404);
        run_vec(32'h4400_0010, 0, 0, 3'b100, 1'b0, 2'b10, 32'h0,        1'b0, 1'b0, 32'h0000_0448);
        // bnc with carry cleared on the same edge sees old carry (1)
        run_vec(32'h4400_0004, 0, 0, 3'b101, 1'b0, 2'b10, 32'h0,        1'b1, 1'b0, 32'h0000_044C);
        run_vec(32'h4400_0004, 0, 0, 3'b101, 1'b0, 2'b10, 32'h0,        1'b0, 1'b0, 32'h0000_0460);
        // bmi with negative 26-bit offset
        run_vec(32'h03FF_FFF8, 0, 0, 3'b001, 1'b0, 2'b00, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0444);
        run_vec(32'h03FF_FFF8, 0, 0, 3'b001, 1'b0, 2'b00, 32'h7FFF_FFFF, 1'b0, 1'b0, 32'h0000_0448);
        // bnz to register, then reserved conditions
        run_vec(32'h0000_0000, 0, 0, 3'b011, 1'b0, 2'b01, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000);
        run_vec(32'hFFFF_FFFF, 0, 0, 3'b111, 1'b0, 2'b00, 32'h0,        1'b0, 1'b0, 32'h0000_0004);
        // PC wrap-around
        run_vec(32'h0000_0000, 0, 0, 3'b000, 1'b1, 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFC);
        run_vec(32'h0000_0001, 0, 0, 3'b000, 1'b0, 2'b11, 32'h0,        1'b0, 1'b0, 32'h0000_0000);
        run_vec(32'h0000_0000, 0, 0, 3'b011, 1'b0, 2'b01, 32'h0,        1'b0, 1'b0, 32'h0000_0004);
        run_vec(32'h0000_FFFF, 0, 0, 3'b110, 1'b0, 2'b10, 32'h0,        1'b0, 1'b0, 32'h0000_0008);

        // Reset in the middle of a fetch drops the request immediately.
        wait_req();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midfetch_rst_req", 32'(imem_req), 32'd0);
        check("midfetch_rst_pc", pc, RstPc);
        reset_release();

`ifdef FETCH_TIMEOUT_EN
        // No ack: HALT after Tmo FETCH cycles.
        repeat (Tmo - 1) @(posedge clk);
        #1;
        check("tmo_last_cycle_req", 32'(imem_req), 32'd1);
        check("tmo_last_cycle_err", 32'(fetch_err), 32'd0);
        @(posedge clk);
        #1;
        check("tmo_halt_req", 32'(imem_req), 32'd0);
        check("tmo_halt_err", 32'(fetch_err), 32'd1);
        check("tmo_halt_valid", 32'(instr_valid), 32'd0);
        imem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        imem_ack = 1'b0;
        check("tmo_err_sticky", 32'(fetch_err), 32'd1);
        check("tmo_halt_stays", 32'(imem_req), 32'd0);
        rst_n = 1'b0;
        #1;
        check("tmo_rst_clears_err", 32'(fetch_err), 32'd0);
        reset_release();
        // Ack on the final watchdog cycle wins.
        run_vec(32'h2000_0004, Tmo - 1, 0, 3'b000, 1'b0, 2'b11, 32'h0, 1'b0, 1'b0, 32'h0000_0104);
        check("tmo_ack_wins_err", 32'(fetch_err), 32'd0);
`else
        // Without the watchdog FETCH waits indefinitely.
        run_vec(32'h2000_0004, 24, 0, 3'b000, 1'b0, 2'b11, 32'h0, 1'b0, 1'b0, 32'h0000_0104);
        check("no_tmo_err", 32'(fetch_err), 32'd0);
`endif

        wait_req();
        repeat (2) @(posedge clk);
        #1;
        check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
        check("exec_q_drained", 32'(exec_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch and next-PC stage of the KGP miniRISC core. It holds the program counter, fetches one instruction at a time from instruction memory over a req/ack handshake, and presents it to decode. On each `exec_done` it computes the next PC from the decoder's `CondJump`/`UncondJump`/`AddrSel` outputs, the branch operand register value and an internal carry flag.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `TIMEOUT`, default 16: fetch watchdog limit in cycles. Used only with `FETCH_TIMEOUT_EN`.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request, held high until acked.
- `imem_addr` out 32: fetch address, equals `pc`.
- `imem_ack` in 1: memory returns data this cycle.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `instr` out 32: latched instruction.
- `instr_valid` out 1: `instr` is valid for decode/execute.
- `pc` out 32: current PC.
- `link_pc` out 32: `pc + 4`, the `bl` writeback value.
- `exec_done` in 1: core finished the current instruction; commit next PC.
- `CondJump` in 3: condition select from the control unit.
- `UncondJump` in 1: unconditional branch.
- `AddrSel` in 2: target select.
- `rs_val` in 32: branch operand register value.
- `carry_we` in 1: update carry flag.
- `carry_in` in 1: new carry value from the ALU.
- `fetch_err` out 1: sticky watchdog error. Tied to 0 without `FETCH_TIMEOUT_EN`.

## Operation
- FSM states: IDLE, FETCH, EXEC, HALT.
  - IDLE→FETCH unconditionally.
  - FETCH→EXEC on `imem_ack`.
  - EXEC→FETCH on `exec_done`.
  - FETCH→HALT on timeout. HALT is left only by reset.
- `imem_req` = (state==FETCH). `imem_ack` is ignored outside FETCH.
- `instr` is loaded from `imem_rdata` on the FETCH ack edge. `instr_valid` = (state==EXEC).
- `exec_done` is ignored outside EXEC.
- Offsets are taken from `instr`:
  - off16 = sext(`instr[15:0]`)<<2
  - off26 = sext(`instr[25:0]`)<<2
- Branch targets:
  - `AddrSel`=00: `pc+4+off26`
  - `AddrSel`=01: {`rs_val[31:2]`,2'b00}
  - `AddrSel`=10: `pc+4+off16`
  - `AddrSel`=11: `pc+4`
- Branch taken conditions:
  - `UncondJump`=1: always taken.
  - `CondJump` 001: `rs_val[31]`
  - `CondJump` 010: `rs_val`==0
  - `CondJump` 011: `rs_val`!=0
  - `CondJump` 100: carry==1
  - `CondJump` 101: carry==0
  - `CondJump` 000, 110, 111: not taken.
- Next PC is the selected target if taken, else `pc+4`. All arithmetic is modulo 2^32; wrap-around is silent.
- Carry flag:
  - Loads `carry_in` on any edge where `carry_we`=1, in any state.
  - Resets to 0.
  - Branch evaluation uses the registered value. If `carry_we` and `exec_done` fall on the same edge, the branch sees the old carry.

## Timing
- Reset values: state=IDLE, `pc`=`RESET_PC`, `instr`=0, carry=0, `imem_req`=0, `instr_valid`=0, `fetch_err`=0, `link_pc`=`RESET_PC+4`.
- First `imem_req` appears 1 cycle after `rst_n` deasserts.
- Ack sampled at edge N → `instr_valid` high from N+1.
- `exec_done` at edge M → new `pc` and `imem_req` from M+1.
- Minimum throughput: 2 cycles per instruction (ack during the first FETCH cycle, `exec_done` during the first EXEC cycle).
- `imem_addr` is stable for the whole FETCH state.
- Reset mid-fetch or mid-exec: immediate return to IDLE. The pending fetch is abandoned and the memory must tolerate a dropped request.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter clears on FETCH entry and increments each FETCH cycle without ack.
  - On reaching `TIMEOUT` with no ack: go to HALT, set `fetch_err`=1 (sticky), `imem_req`=0, `instr_valid`=0.
  - An ack arriving in the same cycle the count reaches `TIMEOUT` wins: normal FETCH→EXEC.
- Undefined: no counter, FETCH waits indefinitely, HALT is unreachable, `fetch_err`=0.

## Test plan
- Reset release with `RESET_PC`=0x100 → `imem_req`=1, `imem_addr`=0x100 next cycle; ack with 0x2000_0004 → `instr`=0x2000_0004, `instr_valid`=1.
- Sequential: 3 instructions, no branches, `exec_done` each → addresses 0x100, 0x104, 0x108.
- `bz` taken: `CondJump`=010, `AddrSel`=10, `rs_val`=0, `instr[15:0]`=0xFFFE, `pc`=0x200 → next `pc`=0x1FC. Same case with `rs_val`=5 → 0x204.
- `br`: `UncondJump`=1, `AddrSel`=01, `rs_val`=0x0000_0403 → next `pc`=0x400. `link_pc`=`pc+4` during EXEC.
- Carry: `carry_we`=1/`carry_in`=1 on the same edge as `exec_done` with `bcy` → not taken. Next `bcy` → taken.
- With `FETCH_TIMEOUT_EN`, `TIMEOUT`=16 and no ack → HALT after 16 FETCH cycles, `fetch_err`=1, `imem_req`=0. Ack on cycle 16 → normal EXEC. Reset clears `fetch_err`.
